nrst_sequencer: RTL and testbench
=================================

Name: nrst_sequencer

Overview:
Parametrised successor to the active-low reset synchronizer. It synchronizes an asynchronous active-low reset into CLK_I, stretches it for a minimum hold time, and accepts a synchronous soft-reset request. It then releases NUM_OUT reset outputs one at a time, in order, with a fixed gap between them. It sits at the top of each clock domain and drives per-subsystem resets plus a reset-done status.

Parameters:
STAGES, 2, synchronizer chain length; must be >= 2 (elaboration error otherwise)
HOLD_CYCLES, 16, cycles reset is held after synchronized release or soft request; must be >= 1
NUM_OUT, 4, number of sequenced reset outputs; must be >= 1
GAP_CYCLES, 4, cycles between consecutive output releases; must be >= 1

Ports:
CLK_I  input  1  clock
NRST_I  input  1  asynchronous reset, active LOW (asynchronous assert, synchronized release)
SRST_REQ_I  input  1  soft-reset request, active HIGH, synchronous to CLK_I
NRST_O  output  NUM_OUT  sequenced resets, active LOW; bit 0 is released first
RST_DONE_O  output  1  high once all NRST_O bits are released
RST_CAUSE_O  output  1  source of the last reset: 0 = NRST_I, 1 = soft request

Behaviour:
- All outputs, state, counters and the sync chain are flops cleared asynchronously by NRST_I low. There are no combinational output paths.
- Reset values: NRST_O = all 0, RST_DONE_O = 0, RST_CAUSE_O = 0, state ASSERT.
- Sync chain: shifts in 1 on each edge after NRST_I rises. Signal sync_n is chain[STAGES-1], which goes high at edge STAGES.
- FSM states: ASSERT, HOLD, RELEASE, DONE.
- ASSERT: NRST_O all 0. When sync_n = 1 is sampled, go to HOLD and load cnt = HOLD_CYCLES-1. This transition occurs at edge STAGES+1.
- HOLD: cnt decrements once per cycle. On the edge where cnt == 0:
  - set NRST_O[0] = 1;
  - set idx = 1, load cnt = GAP_CYCLES-1;
  - go to RELEASE, or to DONE if NUM_OUT = 1.
- RELEASE: cnt decrements once per cycle. On the edge where cnt == 0:
  - set NRST_O[idx] = 1 and increment idx;
  - reload cnt = GAP_CYCLES-1;
  - when idx = NUM_OUT-1 is released, go to DONE.
- DONE: NRST_O all 1. RST_DONE_O goes to 1 on the same edge as the last NRST_O bit.
- NRST_O is a thermometer code: a released bit stays 1 until the next reset event.
- Timing: NRST_O[0] rises at edge STAGES+1+HOLD_CYCLES after NRST_I rises. NRST_O[i] rises GAP_CYCLES edges after NRST_O[i-1].
- Soft reset: SRST_REQ_I is honoured only when sync_n = 1, and has priority over all other transitions. If SRST_REQ_I = 1 is sampled at edge e, then on that edge:
  - NRST_O = all 0, RST_DONE_O = 0, RST_CAUSE_O = 1;
  - state = HOLD, cnt = HOLD_CYCLES-1.
  NRST_O[0] then rises at edge e+HOLD_CYCLES.
- SRST_REQ_I held high keeps reloading HOLD. The hold period counts from the last high sample.
- A soft request during ASSERT (sync_n = 0) is ignored.
- NRST_I asserted at any time, including mid-sequence or mid-soft-reset:
  - all outputs and state clear immediately and asynchronously;
  - RST_CAUSE_O = 0;
  - the full sequence restarts after release.
- Counter width: clog2(max(HOLD_CYCLES, GAP_CYCLES)) bits, minimum 1.
- idx width: clog2(NUM_OUT) bits, minimum 1.
- NRST_I glitch shorter than a clock period: it still clears everything asynchronously, and the full sequence re-runs.

Test Plan:
- Defaults, NRST_I low then released before edge 0 -> NRST_O rises 0001@19, 0011@23, 0111@27, 1111@31; RST_DONE_O=1@31; RST_CAUSE_O=0.
- After DONE, SRST_REQ_I high for 1 cycle sampled at edge e -> NRST_O=0000 and RST_DONE_O=0 after edge e; RST_CAUSE_O=1; NRST_O[0] rises at e+16, all 1111 at e+28.
- SRST_REQ_I held high 10 cycles (last high sample at edge f) -> NRST_O stays 0000 throughout; NRST_O[0] rises at f+16.
- NRST_I pulsed low asynchronously mid-RELEASE (NRST_O=0011) -> NRST_O=0000, RST_DONE_O=0 and RST_CAUSE_O=0 immediately with no clock edge; full 31-edge sequence repeats.
- Parameter sweep STAGES=3, HOLD_CYCLES=1, NUM_OUT=1, GAP_CYCLES=1 -> NRST_O[0] and RST_DONE_O rise at edge 5; SRST_REQ_I sampled high during ASSERT is ignored.

Source files
------------

// File: rtl/nrst_sequencer.sv
// nrst_sequencer: synchronizes NRST_I, holds reset, then releases NRST_O bits one by one with a fixed gap
module nrst_sequencer #(
    parameter int STAGES      = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               CLK_I,
    input  logic               NRST_I,
    input  logic               SRST_REQ_I,
    output logic [NUM_OUT-1:0] NRST_O,
    output logic               RST_DONE_O,
    output logic               RST_CAUSE_O
);
    localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int IW   = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;

    if (STAGES < 2 || HOLD_CYCLES < 1 || NUM_OUT < 1 || GAP_CYCLES < 1) begin : g_bad_param
        $error("nrst_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, DONE} state_t;

    state_t             state_q, state_d;
    logic [STAGES-1:0]  chain_q, chain_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] nrst_q, nrst_d;
    logic               done_q, done_d;
    logic               cause_q, cause_d;
    logic               sync_n;

    assign sync_n      = chain_q[STAGES-1];
    assign NRST_O      = nrst_q;
    assign RST_DONE_O  = done_q;
    assign RST_CAUSE_O = cause_q;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], 1'b1};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nrst_d  = nrst_q;
        done_d  = done_q;
        cause_d = cause_q;
        // a soft request overrides every other transition once the sync chain is released
        if (sync_n && SRST_REQ_I) begin
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYCLES - 1);
            nrst_d  = '0;
            done_d  = 1'b0;
            cause_d = 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (sync_n) begin
                        state_d = HOLD;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        nrst_d[0] = 1'b1;
                        idx_d     = IW'(1);
                        cnt_d     = CW'(GAP_CYCLES - 1);
                        state_d   = NUM_OUT == 1 ? DONE : RELEASE;
                        done_d    = NUM_OUT == 1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == '0) begin
                        nrst_d[idx_q] = 1'b1;
                        idx_d         = idx_q + IW'(1);
                        cnt_d         = CW'(GAP_CYCLES - 1);
                        if (idx_q == IW'(NUM_OUT - 1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            state_q <= ASSERT;
            chain_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            done_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nrst_q  <= nrst_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end
endmodule

// File: tb/tb_nrst_sequencer.sv
// tb_nrst_sequencer: two configurations checked against an edge-count timing model
module tb_nrst_sequencer;
    localparam int S1 = 2, H1 = 16, N1 = 4, G1 = 4;
    localparam int S2 = 3, H2 = 1, N2 = 1, G2 = 1;

    logic clk = 1'b0;
    logic nrst_n, srst;
    logic [N1-1:0] o1;
    logic [N2-1:0] o2;
    logic d1, c1, d2, c2;
    int n_chk = 0, n_fail = 0;
    int k, r1, r2;
    bit cause1, cause2;

    always #5 clk = ~clk;

    nrst_sequencer #(.STAGES(S1), .HOLD_CYCLES(H1), .NUM_OUT(N1), .GAP_CYCLES(G1)) dut1 (
        .CLK_I(clk), .NRST_I(nrst_n), .SRST_REQ_I(srst),
        .NRST_O(o1), .RST_DONE_O(d1), .RST_CAUSE_O(c1));

    nrst_sequencer #(.STAGES(S2), .HOLD_CYCLES(H2), .NUM_OUT(N2), .GAP_CYCLES(G2)) dut2 (
        .CLK_I(clk), .NRST_I(nrst_n), .SRST_REQ_I(srst),
        .NRST_O(o2), .RST_DONE_O(d2), .RST_CAUSE_O(c2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, k, got, exp);
        end
    endtask

    // bit i of a sequenced output is released GAP edges after bit i-1, first at edge r0
    function automatic logic [31:0] exp_vec(input int kk, input int r0, input int gap, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = kk >= r0 + i * gap;
        return v;
    endfunction

    task automatic check_all();
        check("nrst_o_a", 32'(o1), exp_vec(k, r1, G1, N1));
        check("done_a", 32'(d1), 32'(k >= r1 + (N1 - 1) * G1));
        check("cause_a", 32'(c1), 32'(cause1));
        check("nrst_o_b", 32'(o2), exp_vec(k, r2, G2, N2));
        check("done_b", 32'(d2), 32'(k >= r2 + (N2 - 1) * G2));
        check("cause_b", 32'(c2), 32'(cause2));
    endtask

    task automatic model_reset();
        k      = 0;
        r1     = S1 + 1 + H1;
        r2     = S2 + 1 + H2;
        cause1 = 1'b0;
        cause2 = 1'b0;
    endtask

    task automatic step(input bit s);
        srst = s;
        @(posedge clk);
        if (nrst_n) begin
            k++;
            if (s && k >= S1 + 1) begin r1 = k + H1; cause1 = 1'b1; end
            if (s && k >= S2 + 1) begin r2 = k + H2; cause2 = 1'b1; end
        end
        #1;
        check_all();
    endtask

    // glitch shorter than a clock period, placed between edges
    task automatic pulse();
        nrst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2 nrst_n = 1'b1;
    endtask

    initial begin
        nrst_n = 1'b0;
        srst   = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) step(1'b0);
        nrst_n = 1'b1;
        repeat (35) step(1'b0);
        step(1'b1);
        repeat (30) step(1'b0);
        repeat (10) step(1'b1);
        repeat (20) step(1'b0);
        pulse();
        repeat (24) step(1'b0);
        pulse();
        step(1'b1);
        step(1'b1);
        repeat (35) step(1'b0);
        repeat (3000) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                pulse();
                step(1'b0);
            end else if (r < 6) begin
                repeat ($urandom_range(1, 12)) step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
